// File: rtl/bioz_pll_pkg.sv
// Shared types and constants for the BioZ PLL Fsel sweep sequencer.
package bioz_pll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_REQ       = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam logic [3:0] FSEL_REF = 4'd6;
    localparam logic [3:0] FSEL_MAX = 4'd15;

    // Saturating step so the divider code can never wrap around the range ends.
    function automatic logic [3:0] fsel_step(input logic [3:0] cur, input logic down);
        if (down)
            return (cur == 4'd0) ? cur : cur - 4'd1;
        else
            return (cur == FSEL_MAX) ? cur : cur + 4'd1;
    endfunction

endpackage

// File: rtl/bioz_pll_seq_timer.sv
// Loadable down-counter with enable and zero flag; shared by the lock, settle and dwell counts.
module bioz_pll_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bioz_pll_fsel_sequencer.sv
// Steps the PLL output divider select through a start..stop range, gating excitation
// with a settle window, a timed measurement window and a request/ack handshake.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for Start; sweep parameters latched on Start
// WAIT_LOCK  | counting consecutive Lock cycles, lock timeout running
// SETTLE     | Fsel just changed, excitation blanked for SETTLE_CYCLES
// MEASURE    | Fout_en high for the latched Dwell cycles
// REQ        | Meas_req held until Meas_ack
// DONE       | one-cycle Done pulse after the last step
module bioz_pll_fsel_sequencer
    import bioz_pll_pkg::*;
#(
    parameter int DWELL_W       = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int LOCK_STABLE   = 32,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic               Fin,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Lock,
    input  logic [3:0]         Fsel_start,
    input  logic [3:0]         Fsel_stop,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic               Meas_ack,
    output logic [3:0]         Fsel,
    output logic               Fout_en,
    output logic               Meas_req,
    output logic [3:0]         Step_idx,
    output logic               Busy,
    output logic               Done,
    output logic               Lock_err
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam int LS_W = $clog2(LOCK_STABLE + 1);
    localparam int TW_A = (SC_W > LS_W) ? SC_W : LS_W;
    localparam int TW   = (DWELL_W > TW_A) ? DWELL_W : TW_A;
    localparam int TOW  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [TW-1:0]  SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]  LOCK_LOAD   = TW'(LOCK_STABLE - 1);
    localparam logic [TOW-1:0] TO_LAST     = TOW'(LOCK_TIMEOUT - 1);

    state_t state, state_next;

    logic [3:0]         fsel_stop_q;
    logic               down_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [TOW-1:0]     to_cnt;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_zero;

    logic [3:0] fsel_d;
    logic [3:0] step_d;
    logic       lock_err_d;
    logic       accept_start;

    assign accept_start = (state == ST_IDLE) && Start && !Abort;

    bioz_pll_seq_timer #(.W(TW)) u_timer (
        .clk      (Fin),
        .rst      (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Next state and timer control. Abort has top priority, lock loss beats ack/expiry.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = LOCK_LOAD;
        tmr_en     = 1'b0;
        if (Abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state_next = ST_WAIT_LOCK;
                        tmr_load   = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (Lock && tmr_zero) begin
                        state_next = ST_SETTLE;
                        tmr_load   = 1'b1;
                        tmr_val    = SETTLE_LOAD;
                    end else if (to_cnt == TO_LAST) begin
                        state_next = ST_IDLE;
                    end else if (!Lock) begin
                        tmr_load = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!Lock) begin
                        state_next = ST_WAIT_LOCK;
                        tmr_load   = 1'b1;
                    end else if (tmr_zero) begin
                        state_next = ST_MEASURE;
                        tmr_load   = 1'b1;
                        tmr_val    = TW'(dwell_q) - TW'(1);
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (!Lock) begin
                        state_next = ST_WAIT_LOCK;
                        tmr_load   = 1'b1;
                    end else if (tmr_zero) begin
                        state_next = ST_REQ;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!Lock) begin
                        state_next = ST_WAIT_LOCK;
                        tmr_load   = 1'b1;
                    end else if (Meas_ack) begin
                        if (Fsel == fsel_stop_q) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_SETTLE;
                            tmr_load   = 1'b1;
                            tmr_val    = SETTLE_LOAD;
                        end
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fsel_d     = Fsel;
        step_d     = Step_idx;
        lock_err_d = Lock_err;
        if (!Abort) begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        fsel_d     = Fsel_start;
                        step_d     = 4'd0;
                        lock_err_d = 1'b0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (state_next == ST_IDLE)
                        lock_err_d = 1'b1;
                end
                ST_REQ: begin
                    if (state_next == ST_SETTLE) begin
                        fsel_d = fsel_step(Fsel, down_q);
                        step_d = Step_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge Fin or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            Fsel     <= FSEL_REF;
            Step_idx <= 4'd0;
            Lock_err <= 1'b0;
            Fout_en  <= 1'b0;
            Meas_req <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_next;
            Fsel     <= fsel_d;
            Step_idx <= step_d;
            Lock_err <= lock_err_d;
            Fout_en  <= (state_next == ST_MEASURE);
            Meas_req <= (state_next == ST_REQ);
            Busy     <= (state_next != ST_IDLE);
            Done     <= (state_next == ST_DONE);
        end
    end

    always_ff @(posedge Fin or posedge Reset) begin
        if (Reset) begin
            fsel_stop_q <= 4'd0;
            down_q      <= 1'b0;
            dwell_q     <= '0;
            to_cnt      <= '0;
        end else begin
            if (accept_start) begin
                fsel_stop_q <= Fsel_stop;
                down_q      <= (Fsel_stop < Fsel_start);
                dwell_q     <= (Dwell == '0) ? DWELL_W'(1) : Dwell;
            end
            to_cnt <= (state == ST_WAIT_LOCK) ? to_cnt + TOW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_bioz_pll_fsel_sequencer.sv
// Self-checking bench: table-driven and randomized sweeps against a step-level model,
// plus hand sequences for reset, lock timeout and abort precedence.
module tb_bioz_pll_fsel_sequencer;

    localparam int LS = 32;
    localparam int SC = 64;
    localparam int TO = 65535;

    logic        Fin = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Abort;
    logic        Lock;
    logic [3:0]  Fsel_start;
    logic [3:0]  Fsel_stop;
    logic [15:0] Dwell;
    logic        Meas_ack;
    logic [3:0]  Fsel;
    logic        Fout_en;
    logic        Meas_req;
    logic [3:0]  Step_idx;
    logic        Busy;
    logic        Done;
    logic        Lock_err;

    int total = 0;
    int bad   = 0;

    always #5 Fin = ~Fin;

    bioz_pll_fsel_sequencer dut (
        .Fin        (Fin),
        .Reset      (Reset),
        .Start      (Start),
        .Abort      (Abort),
        .Lock       (Lock),
        .Fsel_start (Fsel_start),
        .Fsel_stop  (Fsel_stop),
        .Dwell      (Dwell),
        .Meas_ack   (Meas_ack),
        .Fsel       (Fsel),
        .Fout_en    (Fout_en),
        .Meas_req   (Meas_req),
        .Step_idx   (Step_idx),
        .Busy       (Busy),
        .Done       (Done),
        .Lock_err   (Lock_err)
    );

    typedef struct {
        logic [3:0]  fs;
        logic [3:0]  fe;
        logic [15:0] dw;
        int          ackdly;
        int          drop_step;
        int          drop_after;
        bit          noise;
        int          exp_steps;
        logic [3:0]  exp_final;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one sweep; the model predicts each step's code, index and window lengths.
    task automatic run_sweep(input logic [3:0] fs, input logic [3:0] fe, input logic [15:0] dw,
                             input int ackdly, input int drop_step, input int drop_after,
                             input bit noise, input int exp_steps, input logic [3:0] exp_final);
        int dw_eff;
        bit down;
        int step, low, high, req_cnt, cyc, code;
        bit finished, dropped, first, check_next;
        dw_eff = (dw == 16'd0) ? 1 : int'(dw);
        down = (fe < fs);
        step = 0; low = 0; high = 0; req_cnt = 0; cyc = 0;
        finished = 0; dropped = 0; first = 1; check_next = 0;
        @(negedge Fin);
        Fsel_start = fs; Fsel_stop = fe; Dwell = dw; Start = 1'b1;
        @(negedge Fin);
        Start = 1'b0;
        while (!finished && cyc < 20000) begin
            cyc++;
            Meas_ack = 1'b0;
            Lock = 1'b1;
            if (noise) begin
                Fsel_start = 4'($urandom_range(0, 15));
                Fsel_stop  = 4'($urandom_range(0, 15));
                Dwell      = 16'($urandom_range(0, 40));
                Start      = ($urandom_range(0, 7) == 0);
            end
            if (check_next) begin
                check("lockloss_fout_en", Fout_en, 0);
                check("lockloss_busy", Busy, 1);
                check_next = 0;
            end
            if (Done) begin
                Start = 1'b0;
                check("done_steps", step, exp_steps);
                check("done_fsel", Fsel, exp_final);
                check("done_step_idx", Step_idx, exp_steps - 1);
                finished = 1;
            end else if (Meas_req) begin
                if (req_cnt == 0) begin
                    code = down ? int'(fs) - step : int'(fs) + step;
                    check("step_fsel", Fsel, code);
                    check("step_idx", Step_idx, step);
                    check("step_low_cycles", low, first ? (LS + SC) : SC);
                    check("step_window", high, dw_eff);
                    low = 0; high = 0; first = 0;
                end
                if (req_cnt == ackdly) begin
                    Meas_ack = 1'b1;
                    req_cnt = 0;
                    step++;
                end else begin
                    req_cnt++;
                end
            end else if (Fout_en) begin
                high++;
                if (step == drop_step && !dropped && high == drop_after) begin
                    Lock = 1'b0;
                    dropped = 1; high = 0; low = 0; first = 1; check_next = 1;
                end
            end else if (Busy) begin
                low++;
            end
            @(negedge Fin);
        end
        Start = 1'b0;
        check("sweep_finished", finished, 1);
        check("post_busy", Busy, 0);
        check("post_done", Done, 0);
        check("post_fsel", Fsel, exp_final);
    endtask

    initial begin
        int cnt, dones, n, dwe, dstep, dafter;
        logic [3:0]  rfs, rfe;
        logic [15:0] rdw;

        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Lock = 1'b1;
        Fsel_start = 4'd0; Fsel_stop = 4'd0; Dwell = 16'd0; Meas_ack = 1'b0;

        vecs[0] = '{4'd3,  4'd5,  16'd10, 2, -1, 0, 1'b0, 3,  4'd5};
        vecs[1] = '{4'd9,  4'd7,  16'd10, 2, -1, 0, 1'b0, 3,  4'd7};
        vecs[2] = '{4'd2,  4'd2,  16'd0,  1, -1, 0, 1'b0, 1,  4'd2};
        vecs[3] = '{4'd3,  4'd5,  16'd10, 2,  1, 5, 1'b0, 3,  4'd5};
        vecs[4] = '{4'd0,  4'd15, 16'd1,  0, -1, 0, 1'b1, 16, 4'd15};
        vecs[5] = '{4'd15, 4'd12, 16'd3,  3,  2, 3, 1'b1, 4,  4'd12};

        repeat (3) @(negedge Fin);
        check("rst_fsel", Fsel, 6);
        check("rst_fout_en", Fout_en, 0);
        check("rst_meas_req", Meas_req, 0);
        check("rst_step_idx", Step_idx, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_lock_err", Lock_err, 0);
        Reset = 1'b0;
        repeat (5) @(negedge Fin);
        check("idle_busy", Busy, 0);
        check("idle_fout_en", Fout_en, 0);
        check("idle_fsel", Fsel, 6);

        for (int i = 0; i < 6; i++)
            run_sweep(vecs[i].fs, vecs[i].fe, vecs[i].dw, vecs[i].ackdly, vecs[i].drop_step,
                      vecs[i].drop_after, vecs[i].noise, vecs[i].exp_steps, vecs[i].exp_final);

        for (int r = 0; r < 6; r++) begin
            rfs = 4'($urandom_range(0, 15));
            rfe = 4'($urandom_range(0, 15));
            rdw = 16'($urandom_range(0, 12));
            n = (rfe >= rfs) ? int'(rfe) - int'(rfs) + 1 : int'(rfs) - int'(rfe) + 1;
            dwe = (rdw == 16'd0) ? 1 : int'(rdw);
            dstep = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            dafter = int'($urandom_range(1, dwe));
            run_sweep(rfs, rfe, rdw, int'($urandom_range(0, 3)), dstep, dafter, 1'b1, n, rfe);
        end

        // Asynchronous reset in the middle of a sweep.
        @(negedge Fin);
        Fsel_start = 4'd9; Fsel_stop = 4'd11; Dwell = 16'd5; Start = 1'b1;
        @(negedge Fin);
        Start = 1'b0;
        repeat (60) @(negedge Fin);
        check("midsweep_busy", Busy, 1);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_fsel", Fsel, 6);
        check("async_rst_busy", Busy, 0);
        @(negedge Fin);
        Reset = 1'b0;

        // Abort together with Meas_ack in REQ.
        @(negedge Fin);
        Fsel_start = 4'd3; Fsel_stop = 4'd5; Dwell = 16'd4; Start = 1'b1;
        @(negedge Fin);
        Start = 1'b0;
        cnt = 0;
        while (!Meas_req && cnt < 500) begin
            cnt++;
            @(negedge Fin);
        end
        check("abort_reached_req", Meas_req, 1);
        Abort = 1'b1; Meas_ack = 1'b1;
        @(negedge Fin);
        Abort = 1'b0; Meas_ack = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_meas_req", Meas_req, 0);
        check("abort_done", Done, 0);
        check("abort_fsel", Fsel, 3);
        check("abort_step_idx", Step_idx, 0);
        dones = 0;
        repeat (4) begin
            @(negedge Fin);
            if (Done || Busy) dones++;
        end
        check("abort_quiet", dones, 0);

        // Lock never asserts: timeout sets Lock_err without Done.
        Lock = 1'b0;
        Fsel_start = 4'd1; Fsel_stop = 4'd2; Dwell = 16'd3; Start = 1'b1;
        @(negedge Fin);
        Start = 1'b0;
        cnt = 0; dones = 0;
        while (Busy && cnt < 70000) begin
            cnt++;
            if (Done) dones++;
            @(negedge Fin);
        end
        check("timeout_cycles", cnt, TO);
        check("timeout_lock_err", Lock_err, 1);
        check("timeout_busy", Busy, 0);
        check("timeout_no_done", dones, 0);
        Lock = 1'b1; Start = 1'b1;
        @(negedge Fin);
        Start = 1'b0;
        check("restart_clears_lock_err", Lock_err, 0);
        check("restart_busy", Busy, 1);
        Abort = 1'b1;
        @(negedge Fin);
        Abort = 1'b0;
        check("abort_wait_lock_busy", Busy, 0);
        check("abort_wait_lock_err", Lock_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bioz_pll_fsel_sequencer.md
Name: bioz_pll_fsel_sequencer

Overview:
Controls the PLL frequency divider's 4-bit output selector (Fsel) for multi-frequency BioZ sweeps. Waits for PLL lock, then steps Fsel from a start code to a stop code. At each step it blanks the excitation during a settle window, opens a timed measurement window, and handshakes a completion request with the measurement block. Runs on the VCO clock domain (Fin, 32 MHz when locked).

Parameters:
DWELL_W, 16, width of the Dwell window-length input (Fin cycles).
SETTLE_CYCLES, 64, Fin cycles Fout_en stays low after every Fsel change.
LOCK_STABLE, 32, consecutive Lock-high cycles that count as locked.
LOCK_TIMEOUT, 65535, Fin cycles allowed in WAIT_LOCK before Lock_err.

Ports:
Fin  in  1  clock (VCO output).
Reset  in  1  asynchronous, active-high reset.
Start  in  1  single-cycle sweep start pulse; honoured only in IDLE.
Abort  in  1  synchronous sweep abort; any state.
Lock  in  1  PLL lock indicator, synchronous to Fin.
Fsel_start  in  4  first divider select code.
Fsel_stop  in  4  last divider select code.
Dwell  in  DWELL_W  measurement window length in Fin cycles.
Meas_ack  in  1  measurement block has consumed the step result.
Fsel  out  4  registered select driven to the frequency divider.
Fout_en  out  1  excitation enable; high only in MEASURE.
Meas_req  out  1  step-complete request; held until acknowledged.
Step_idx  out  4  zero-based index of the current step.
Busy  out  1  high in every state except IDLE.
Done  out  1  one-cycle pulse after the last step is acknowledged.
Lock_err  out  1  sticky lock-timeout flag; cleared by the next accepted Start.

Behaviour:
- Reset: Fsel=4'b0110 (500 kHz PFD reference code); all other outputs 0; state IDLE; all counters 0.
- States: IDLE, WAIT_LOCK, SETTLE, MEASURE, REQ, DONE.
- IDLE: on Start, latch Fsel_start, Fsel_stop and Dwell. A latched Dwell of 0 is treated as 1. Set direction to down if stop<start, else up. Fsel<=start, Step_idx<=0, Lock_err<=0; go to WAIT_LOCK the next cycle.
- WAIT_LOCK: count consecutive Lock=1 cycles; a Lock=0 cycle restarts the count. When the count reaches LOCK_STABLE, go to SETTLE. If LOCK_TIMEOUT total cycles elapse first, set Lock_err=1 and return to IDLE with no Done pulse.
- SETTLE: Fout_en=0 for exactly SETTLE_CYCLES cycles, then go to MEASURE.
- MEASURE: Fout_en=1 for exactly Dwell cycles, then go to REQ (Fout_en=0).
- REQ: Meas_req=1 until Meas_ack=1 is sampled. An ack arriving in the same cycle Meas_req rises counts. Meas_ack outside REQ is ignored.
- On ack, if Fsel==latched stop: go to DONE. DONE pulses Done for 1 cycle, then returns to IDLE. Fsel holds the last code.
- On ack, otherwise: Fsel steps +/-1 per direction, Step_idx+1, go to SETTLE. No re-lock is needed; the divider is downstream of the PLL loop.
- Fsel never wraps. start==stop gives exactly one step.
- Lock loss: Lock=0 in SETTLE, MEASURE or REQ causes the following on the next cycle:
  - Fout_en=0 and Meas_req=0;
  - go to WAIT_LOCK and retry the same step (same Fsel and Step_idx);
  - the settle and dwell counters restart.
- Abort: go to IDLE on the next cycle with Fout_en=0 and Meas_req=0. No Done pulse; Fsel keeps its current value. Abort beats Meas_ack, Lock loss and counter expiry when they occur in the same cycle.
- Start while Busy is ignored. Input changes after the latch have no effect until the next Start.
- Reset asserted mid-sweep returns to the reset values immediately (asynchronous).
- All outputs are registered; Fsel changes only on state-transition edges.

Decomposition:
- Shared package bioz_pll_pkg: state enum; FSEL_REF=4'd6; FSEL_MAX=4'd15.
- Sub-module bioz_pll_seq_timer: a loadable down-counter with load, enable and zero flag. One instance is time-shared across the lock-stable, settle and dwell counts. The lock timeout uses a separate free counter inside WAIT_LOCK.

Test Plan:
- Reset check: assert Reset with Lock=1 -> Fsel=6 and all other outputs 0; after release, Busy=0 with no activity.
- Ascending sweep: start=3, stop=5, Dwell=10, Lock held high, ack 2 cycles after each Meas_req -> Fsel sequence 3,4,5 and Step_idx 0,1,2. Each step has exactly 64 Fout_en-low cycles followed by 10 high cycles. Done pulses once, then Busy=0 with Fsel=5.
- Descending single step and Dwell=0: start=9, stop=7 -> Fsel sequence 9,8,7. Separately, start=stop=2 with Dwell=0 -> one step with a 1-cycle Fout_en window, then Done.
- Lock loss: drop Lock for 1 cycle mid-MEASURE at Fsel=4 -> Fout_en falls the next cycle and the state returns to WAIT_LOCK. After 32 stable cycles, a full SETTLE/MEASURE is rerun at Fsel=4 with Step_idx unchanged.
- Lock timeout: Lock=0 throughout after Start -> Lock_err=1 after 65535 cycles, Busy=0 and no Done. The next Start clears Lock_err.
- Abort precedence: assert Abort and Meas_ack together in REQ -> IDLE the next cycle, Meas_req=0, no Done, Fsel unchanged. Start during Busy -> ignored.
